rps_match_controller: RTL and testbench
=======================================

RPS_MATCH_CONTROLLER -- requirements
Module: rps_match_controller

Interface
REQ-001 SHALL have parameter WIN_TARGET, default 3: round wins needed to take the match (1..15).
REQ-002 SHALL have parameter MAX_ROUNDS, default 9: scored-round cap (1..15).
REQ-003 SHALL have parameter TIMEOUT, default 255: COLLECT cycles allowed per round (2..255).
REQ-004 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port match_start  in  1  level-sampled; starts a match from IDLE or DONE.
REQ-007 SHALL have ports p1_valid/p2_valid  in  1 each  move offered by player 1/2.
REQ-008 SHALL have ports p1_move/p2_move  in  2 each  move code: 00 stone, 01 paper, 10 scissors, 11 illegal.
REQ-009 SHALL have ports p1_ready/p2_ready  out  1 each  controller accepts that player's move.
REQ-010 SHALL have port eval_req  out  1  request to the round evaluator.
REQ-011 SHALL have ports eval_p1/eval_p2  out  2 each  latched moves presented to the evaluator.
REQ-012 SHALL have port eval_ack  in  1  evaluator result valid.
REQ-013 SHALL have port eval_result  in  2  00 draw, 01 P1 wins, 10 P2 wins, 11 invalid.
REQ-014 SHALL have ports score1/score2  out  4 each  round wins per player.
REQ-015 SHALL have port round_cnt  out  4  scored rounds played.
REQ-016 SHALL have port match_done  out  1; port match_winner  out  2 (00 tie, 01 P1, 10 P2); port state  out  3.

Function
REQ-017 SHALL implement states IDLE=000, COLLECT=001, EVAL=010, UPDATE=011, DONE=100, driven on state; other codes SHALL go to IDLE next cycle.
REQ-018 IDLE: match_start=1 SHALL go to COLLECT next cycle, clearing scores, round_cnt, latched moves, timer.
REQ-019 COLLECT: pN_ready SHALL be 1 until that player's move is accepted (pN_valid&pN_ready at an edge), then 0 for the rest of the round; both players MAY be accepted in the same cycle.
REQ-020 COLLECT: timer SHALL start at 0 on entry and increment each COLLECT cycle; on the edge where both moves are held, SHALL go to EVAL.
REQ-021 COLLECT timeout: if timer reaches TIMEOUT-1 with a move still missing, SHALL go to UPDATE with forced result: only P1 missing -> 10; only P2 missing -> 01; both missing -> 00; a move accepted on that same edge SHALL count as present.
REQ-022 EVAL: eval_req SHALL be 1 and eval_p1/eval_p2 stable until the edge with eval_ack=1; eval_result SHALL be captured on that edge and state SHALL go to UPDATE; no timeout in EVAL.
REQ-023 UPDATE (one cycle): result 01 -> score1+1; 10 -> score2+1; 00 -> no score; all three SHALL increment round_cnt; result 11 SHALL change neither scores nor round_cnt (round replayed).
REQ-024 UPDATE exit: if a score equals WIN_TARGET or round_cnt equals MAX_ROUNDS (post-update values) SHALL go to DONE, else to COLLECT with moves and timer cleared.
REQ-025 DONE: match_done=1; match_winner = player whose score is higher, 00 if equal; scores and round_cnt held.
REQ-026 DONE: match_start=1 SHALL start a new match exactly as REQ-018; match_start in COLLECT/EVAL/UPDATE SHALL be ignored.
REQ-027 Scores SHALL never exceed WIN_TARGET; round_cnt SHALL never exceed MAX_ROUNDS.
REQ-028 All outputs SHALL be registered or decoded from state registers only; no input-to-output combinational path.

Reset
REQ-029 reset=1 SHALL immediately force state=IDLE, all ready/eval_req/match_done=0, scores, round_cnt, match_winner, eval_p1/p2, timer = 0, including mid-EVAL with eval_req high.
REQ-030 After reset deasserts, SHALL stay in IDLE until match_start=1 is sampled.

Verification
REQ-031 Start; P1=01, P2=00 accepted same cycle -> eval_req next cycle with eval_p1=01, eval_p2=00; ack with 01 -> score1=1, round_cnt=1, back to COLLECT.
REQ-032 P1 wins three rounds (WIN_TARGET=3) -> DONE after 3rd UPDATE, match_done=1, match_winner=01, score1=3.
REQ-033 Only P2 submits, P1 silent TIMEOUT cycles -> UPDATE with score2+1, round_cnt+1; both silent -> round_cnt+1, scores unchanged.
REQ-034 eval_result=11 -> scores and round_cnt unchanged, COLLECT re-entered; eval_ack delayed 10 cycles -> eval_req/eval_p1/eval_p2 held stable throughout.
REQ-035 MAX_ROUNDS=9 all draws -> DONE with round_cnt=9, match_winner=00; match_start in DONE -> COLLECT, all counts 0.
REQ-036 reset pulse while in EVAL -> state=000, eval_req=0, scores 0 asynchronously; match_start during COLLECT -> no effect.

Source files
------------

// File: rtl/rps_match_if.sv
// Bus between the RPS match controller and its players, evaluator and host.
// The master modport is the environment side; the slave modport is the controller.
interface rps_match_if;
    logic       match_start;
    logic       p1_valid;
    logic       p2_valid;
    logic [1:0] p1_move;
    logic [1:0] p2_move;
    logic       p1_ready;
    logic       p2_ready;
    logic       eval_req;
    logic [1:0] eval_p1;
    logic [1:0] eval_p2;
    logic       eval_ack;
    logic [1:0] eval_result;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [3:0] round_cnt;
    logic       match_done;
    logic [1:0] match_winner;
    logic [2:0] state;

    modport master (
        output match_start, p1_valid, p2_valid, p1_move, p2_move, eval_ack, eval_result,
        input  p1_ready, p2_ready, eval_req, eval_p1, eval_p2, score1, score2,
               round_cnt, match_done, match_winner, state
    );

    modport slave (
        input  match_start, p1_valid, p2_valid, p1_move, p2_move, eval_ack, eval_result,
        output p1_ready, p2_ready, eval_req, eval_p1, eval_p2, score1, score2,
               round_cnt, match_done, match_winner, state
    );
endinterface

// File: rtl/rps_match_controller.sv
// Rock-paper-scissors match controller: collects both moves, hands them to an
// external evaluator, keeps score and declares the match winner.
module rps_match_controller #(
    parameter int unsigned WIN_TARGET = 3,
    parameter int unsigned MAX_ROUNDS = 9,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    rps_match_if.slave  bus
);

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned TIMER_W = 8;
    localparam int unsigned MOVE_W  = 2;

    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_COLLECT = 3'b001;
    localparam logic [2:0] S_EVAL    = 3'b010;
    localparam logic [2:0] S_UPDATE  = 3'b011;
    localparam logic [2:0] S_DONE    = 3'b100;

    localparam logic [1:0] RES_DRAW    = 2'b00;
    localparam logic [1:0] RES_P1      = 2'b01;
    localparam logic [1:0] RES_P2      = 2'b10;
    localparam logic [1:0] RES_INVALID = 2'b11;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               r_p1_held;
    logic               r_p2_held;
    logic [MOVE_W-1:0]  r_p1_move;
    logic [MOVE_W-1:0]  r_p2_move;
    logic [1:0]         r_result;
    logic [TIMER_W-1:0] r_timer;
    logic [SCORE_W-1:0] r_score1;
    logic [SCORE_W-1:0] r_score2;
    logic [SCORE_W-1:0] r_round_cnt;
    logic [1:0]         r_winner;

    logic               w_in_collect;
    logic               w_p1_acc;
    logic               w_p2_acc;
    logic               w_p1_have;
    logic               w_p2_have;
    logic               w_both_have;
    logic               w_timeout;
    logic [1:0]         w_forced;
    logic [SCORE_W-1:0] w_score1_upd;
    logic [SCORE_W-1:0] w_score2_upd;
    logic [SCORE_W-1:0] w_round_upd;
    logic               w_match_over;

    // Move acceptance; a move accepted on this edge counts as present.
    assign w_in_collect = (r_state == S_COLLECT);
    assign w_p1_acc     = w_in_collect & bus.p1_valid & ~r_p1_held;
    assign w_p2_acc     = w_in_collect & bus.p2_valid & ~r_p2_held;
    assign w_p1_have    = r_p1_held | w_p1_acc;
    assign w_p2_have    = r_p2_held | w_p2_acc;
    assign w_both_have  = w_p1_have & w_p2_have;
    assign w_timeout    = (r_timer == TIMER_W'(TIMEOUT - 1));

    // Forfeit result: the player who showed up wins, nobody showing is a draw.
    assign w_forced = {~w_p1_have & w_p2_have, w_p1_have & ~w_p2_have};

    // Post-update score values; an invalid result leaves everything untouched.
    assign w_score1_upd = r_score1 + SCORE_W'(r_result == RES_P1);
    assign w_score2_upd = r_score2 + SCORE_W'(r_result == RES_P2);
    assign w_round_upd  = r_round_cnt + SCORE_W'(r_result != RES_INVALID);
    assign w_match_over = (w_score1_upd == SCORE_W'(WIN_TARGET)) |
                          (w_score2_upd == SCORE_W'(WIN_TARGET)) |
                          (w_round_upd  == SCORE_W'(MAX_ROUNDS));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; unused encodings fall back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.match_start) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_both_have) begin
                    w_state_nxt = S_EVAL;
                end else if (w_timeout) begin
                    w_state_nxt = S_UPDATE;
                end
            end
            S_EVAL: begin
                if (bus.eval_ack) begin
                    w_state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_state_nxt = w_match_over ? S_DONE : S_COLLECT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Round datapath: move latches, timer, result capture and scoring.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p1_held   <= 1'b0;
            r_p2_held   <= 1'b0;
            r_p1_move   <= '0;
            r_p2_move   <= '0;
            r_result    <= RES_DRAW;
            r_timer     <= '0;
            r_score1    <= '0;
            r_score2    <= '0;
            r_round_cnt <= '0;
            r_winner    <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.match_start) begin
                        r_p1_held   <= 1'b0;
                        r_p2_held   <= 1'b0;
                        r_p1_move   <= '0;
                        r_p2_move   <= '0;
                        r_result    <= RES_DRAW;
                        r_timer     <= '0;
                        r_score1    <= '0;
                        r_score2    <= '0;
                        r_round_cnt <= '0;
                        r_winner    <= 2'b00;
                    end
                end
                S_COLLECT: begin
                    if (w_p1_acc) begin
                        r_p1_held <= 1'b1;
                        r_p1_move <= bus.p1_move;
                    end
                    if (w_p2_acc) begin
                        r_p2_held <= 1'b1;
                        r_p2_move <= bus.p2_move;
                    end
                    if (!w_both_have && w_timeout) begin
                        r_result <= w_forced;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                S_EVAL: begin
                    if (bus.eval_ack) begin
                        r_result <= bus.eval_result;
                    end
                end
                S_UPDATE: begin
                    r_score1    <= w_score1_upd;
                    r_score2    <= w_score2_upd;
                    r_round_cnt <= w_round_upd;
                    if (w_match_over) begin
                        if (w_score1_upd > w_score2_upd) begin
                            r_winner <= 2'b01;
                        end else if (w_score2_upd > w_score1_upd) begin
                            r_winner <= 2'b10;
                        end else begin
                            r_winner <= 2'b00;
                        end
                    end else begin
                        r_p1_held <= 1'b0;
                        r_p2_held <= 1'b0;
                        r_p1_move <= '0;
                        r_p2_move <= '0;
                        r_timer   <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs come straight from registers or from decodes of the state register.
    assign bus.state        = r_state;
    assign bus.p1_ready     = w_in_collect & ~r_p1_held;
    assign bus.p2_ready     = w_in_collect & ~r_p2_held;
    assign bus.eval_req     = (r_state == S_EVAL);
    assign bus.eval_p1      = r_p1_move;
    assign bus.eval_p2      = r_p2_move;
    assign bus.score1       = r_score1;
    assign bus.score2       = r_score2;
    assign bus.round_cnt    = r_round_cnt;
    assign bus.match_done   = (r_state == S_DONE);
    assign bus.match_winner = r_winner;

endmodule

// File: tb/tb_rps_match_controller.sv
// Self-checking bench for rps_match_controller: round-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_rps_match_controller;

    localparam int WIN = 3;
    localparam int MAXR = 9;
    localparam int TMO = 255;

    localparam logic [2:0] IDLE = 3'd0, COLLECT = 3'd1, EVAL = 3'd2, UPDATE = 3'd3, DONE = 3'd4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vecs = 0;
    int   miss = 0;

    rps_match_if bus ();

    rps_match_controller #(.WIN_TARGET(WIN), .MAX_ROUNDS(MAXR), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what phase of the round we are in and what has been scored.
    logic [2:0] m_ph;
    logic       m_h1, m_h2, ma1, ma2;
    logic [1:0] m_mv1, m_mv2, m_res;
    int         m_t, m_s1, m_s2, m_rc, n1, n2, nrc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph <= IDLE; m_h1 <= 0; m_h2 <= 0; m_mv1 <= 0; m_mv2 <= 0; m_res <= 0;
            m_t <= 0; m_s1 <= 0; m_s2 <= 0; m_rc <= 0;
        end else begin
            case (m_ph)
                IDLE, DONE: if (bus.match_start) begin
                    m_ph <= COLLECT; m_h1 <= 0; m_h2 <= 0; m_mv1 <= 0; m_mv2 <= 0;
                    m_t <= 0; m_s1 <= 0; m_s2 <= 0; m_rc <= 0;
                end
                COLLECT: begin
                    ma1 = m_h1 || bus.p1_valid;
                    ma2 = m_h2 || bus.p2_valid;
                    if (!m_h1 && bus.p1_valid) m_mv1 <= bus.p1_move;
                    if (!m_h2 && bus.p2_valid) m_mv2 <= bus.p2_move;
                    m_h1 <= ma1; m_h2 <= ma2;
                    if (ma1 && ma2) m_ph <= EVAL;
                    else if (m_t == TMO - 1) begin
                        m_ph <= UPDATE;
                        m_res <= (ma1 && !ma2) ? 2'b01 : (!ma1 && ma2) ? 2'b10 : 2'b00;
                    end else m_t <= m_t + 1;
                end
                EVAL: if (bus.eval_ack) begin m_res <= bus.eval_result; m_ph <= UPDATE; end
                UPDATE: begin
                    n1  = m_s1 + ((m_res == 2'b01) ? 1 : 0);
                    n2  = m_s2 + ((m_res == 2'b10) ? 1 : 0);
                    nrc = m_rc + ((m_res == 2'b11) ? 0 : 1);
                    m_s1 <= n1; m_s2 <= n2; m_rc <= nrc;
                    if (n1 == WIN || n2 == WIN || nrc == MAXR) m_ph <= DONE;
                    else begin
                        m_ph <= COLLECT; m_h1 <= 0; m_h2 <= 0; m_mv1 <= 0; m_mv2 <= 0; m_t <= 0;
                    end
                end
                default: m_ph <= IDLE;
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    logic [24:0] act_v, exp_v;
    logic [1:0]  exp_win;
    always @(negedge clk) begin
        exp_win = (m_ph != DONE) ? 2'b00 : (m_s1 > m_s2) ? 2'b01 : (m_s2 > m_s1) ? 2'b10 : 2'b00;
        exp_v = {m_ph, (m_ph == COLLECT) && !m_h1, (m_ph == COLLECT) && !m_h2, m_ph == EVAL,
                 m_mv1, m_mv2, 4'(m_s1), 4'(m_s2), 4'(m_rc), m_ph == DONE, exp_win};
        act_v = {bus.state, bus.p1_ready, bus.p2_ready, bus.eval_req, bus.eval_p1, bus.eval_p2,
                 bus.score1, bus.score2, bus.round_cnt, bus.match_done, bus.match_winner};
        chk("cycle_outputs", 32'(act_v), 32'(exp_v));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (bus.state !== s && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(bus.state), 32'(s));
    endtask

    task automatic start_match();
        bus.match_start = 1'b1;
        tick();
        bus.match_start = 1'b0;
    endtask

    // One full evaluated round; returns with the DUT just past UPDATE.
    task automatic play(input logic [1:0] m1, input logic [1:0] m2, input logic [1:0] res, input int dly);
        wait_state(COLLECT, 20, "play_collect");
        bus.p1_valid = 1'b1; bus.p1_move = m1;
        bus.p2_valid = 1'b1; bus.p2_move = m2;
        tick();
        bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;
        chk("play_eval_req", 32'(bus.eval_req), 32'd1);
        for (int i = 0; i < dly; i++) begin
            chk("hold_eval_p1", 32'(bus.eval_p1), 32'(m1));
            chk("hold_eval_p2", 32'(bus.eval_p2), 32'(m2));
            tick();
        end
        bus.eval_ack = 1'b1; bus.eval_result = res;
        tick();
        bus.eval_ack = 1'b0;
        tick();
    endtask

    task automatic count_collect(output int n);
        n = 0;
        while (bus.state == COLLECT && n < 400) begin
            n++;
            tick();
            bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.match_start = 0; bus.p1_valid = 0; bus.p2_valid = 0; bus.p1_move = 0; bus.p2_move = 0;
        bus.eval_ack = 0; bus.eval_result = 0;
        repeat (2) tick();
        reset = 1'b0;
        chk("reset_state", 32'(bus.state), 32'd0);
        chk("reset_score1", 32'(bus.score1), 32'd0);
        chk("reset_ready", 32'({bus.p1_ready, bus.p2_ready, bus.eval_req, bus.match_done}), 32'd0);
        repeat (3) tick();
        chk("idle_hold", 32'(bus.state), 32'(IDLE));

        // First round, both moves in one cycle, P1 wins.
        start_match();
        chk("start_collect", 32'(bus.state), 32'(COLLECT));
        chk("start_ready", 32'({bus.p1_ready, bus.p2_ready}), 32'd3);
        bus.p1_valid = 1; bus.p1_move = 2'b01; bus.p2_valid = 1; bus.p2_move = 2'b00;
        tick();
        bus.p1_valid = 0; bus.p2_valid = 0;
        chk("r1_eval_req", 32'(bus.eval_req), 32'd1);
        chk("r1_eval_moves", 32'({bus.eval_p1, bus.eval_p2}), 32'b0100);
        bus.eval_ack = 1; bus.eval_result = 2'b01;
        tick();
        bus.eval_ack = 0;
        chk("r1_update", 32'(bus.state), 32'(UPDATE));
        tick();
        chk("r1_back_collect", 32'(bus.state), 32'(COLLECT));
        chk("r1_score1", 32'(bus.score1), 32'd1);
        chk("r1_round", 32'(bus.round_cnt), 32'd1);

        // P1 takes the match on the third win.
        play(2'b10, 2'b01, 2'b01, 0);
        chk("r2_state", 32'(bus.state), 32'(COLLECT));
        play(2'b00, 2'b10, 2'b01, 0);
        chk("win_done", 32'({bus.state, bus.match_done}), 32'({DONE, 1'b1}));
        chk("win_winner", 32'(bus.match_winner), 32'd1);
        chk("win_score1", 32'(bus.score1), 32'd3);

        // Timeouts: only P2 shows, then nobody shows.
        start_match();
        chk("restart_round", 32'({bus.score1, bus.round_cnt}), 32'd0);
        bus.p2_valid = 1; bus.p2_move = 2'b01;
        count_collect(n);
        chk("tmo_len_p2only", 32'(n), 32'(TMO));
        chk("tmo_update", 32'(bus.state), 32'(UPDATE));
        tick();
        chk("tmo_p2_score", 32'({bus.score1, bus.score2, bus.round_cnt}), 32'h011);
        count_collect(n);
        chk("tmo_len_none", 32'(n), 32'(TMO));
        tick();
        chk("tmo_none_score", 32'({bus.score1, bus.score2, bus.round_cnt}), 32'h012);

        // Invalid result with a slow evaluator: round replayed.
        play(2'b11, 2'b00, 2'b11, 10);
        chk("inv_state", 32'(bus.state), 32'(COLLECT));
        chk("inv_score", 32'({bus.score1, bus.score2, bus.round_cnt}), 32'h012);

        // match_start ignored mid-match; staggered acceptance.
        bus.match_start = 1;
        repeat (3) tick();
        bus.match_start = 0;
        chk("start_ignored", 32'({bus.state, bus.score2, bus.round_cnt}), 32'({COLLECT, 4'd1, 4'd2}));
        bus.p1_valid = 1; bus.p1_move = 2'b10;
        tick();
        bus.p1_valid = 0;
        chk("p1_only_ready", 32'({bus.p1_ready, bus.p2_ready}), 32'b01);
        bus.p2_valid = 1; bus.p2_move = 2'b01;
        tick();
        bus.p2_valid = 0;
        chk("stag_eval", 32'({bus.eval_req, bus.eval_p1, bus.eval_p2}), 32'b11001);

        // Asynchronous reset in EVAL.
        reset = 1'b1;
        #1;
        chk("async_rst", 32'({bus.state, bus.eval_req, bus.score2, bus.eval_p1}), 32'd0);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("post_rst_idle", 32'(bus.state), 32'(IDLE));

        // Nine draws hit the round cap.
        start_match();
        for (int r = 0; r < MAXR; r++) play(2'b00, 2'b00, 2'b00, 0);
        chk("draws_done", 32'({bus.state, bus.round_cnt}), 32'({DONE, 4'd9}));
        chk("draws_winner", 32'({bus.match_done, bus.match_winner}), 32'b100);
        start_match();
        chk("draws_restart", 32'({bus.state, bus.score1, bus.score2, bus.round_cnt}), 32'({COLLECT, 12'd0}));

        // P2 sweeps.
        for (int r = 0; r < WIN; r++) play(2'b00, 2'b01, 2'b10, 1);
        chk("p2_winner", 32'({bus.state, bus.match_winner, bus.score2}), 32'({DONE, 2'b10, 4'd3}));

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
